// File: rtl/mem_stage_if.sv
// mem_stage_if: upstream instruction, data-memory and writeback signals of mem_stage
interface mem_stage_if #(parameter int STALL_CNT_W = 16);
    logic                   in_valid;
    logic                   in_ready;
    logic [5:0]             in_opcode;
    logic [31:0]            in_rslt;
    logic [31:0]            in_rrt;
    logic [4:0]             in_rd;
    logic                   in_we;
    logic                   mem_req;
    logic                   mem_we;
    logic [29:0]            mem_addr;
    logic [31:0]            mem_wdata;
    logic                   mem_gnt;
    logic                   mem_rvalid;
    logic [31:0]            mem_rdata;
    logic                   wb_valid;
    logic                   wb_we;
    logic [4:0]             wb_rd;
    logic [31:0]            wb_data;
    logic                   fault;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport slave (
        input  in_valid, in_opcode, in_rslt, in_rrt, in_rd, in_we,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output wb_valid, wb_we, wb_rd, wb_data, fault, stall_cnt
    );

    modport master (
        output in_valid, in_opcode, in_rslt, in_rrt, in_rd, in_we,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  wb_valid, wb_we, wb_rd, wb_data, fault, stall_cnt
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: post-ALU stage issuing single-outstanding LW/SW word accesses and one writeback beat per instruction
module mem_stage #(
    parameter int         STALL_CNT_W = 16,
    parameter logic [5:0] LW_OPCODE   = 6'h23,
    parameter logic [5:0] SW_OPCODE   = 6'h2B
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   rdy_q;
    logic                   mem_we_q, mem_we_d;
    logic [29:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [4:0]             rd_q, rd_d;
    logic                   we_q, we_d;
    logic                   wb_valid_q, wb_valid_d;
    logic                   wb_we_q, wb_we_d;
    logic [4:0]             wb_rd_q, wb_rd_d;
    logic [31:0]            wb_data_q, wb_data_d;
    logic                   fault_q, fault_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   accept, is_mem, load_done;

    // rdy_q keeps in_ready low until the first edge after reset release
    assign bus.in_ready  = rdy_q && (state_q == IDLE);
    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_we     = wb_we_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.fault     = fault_q;
    assign bus.stall_cnt = stall_q;

    always_comb begin
        accept     = bus.in_valid && bus.in_ready;
        is_mem     = (bus.in_opcode == LW_OPCODE) || (bus.in_opcode == SW_OPCODE);
        load_done  = !mem_we_q && bus.mem_rvalid &&
                     ((state_q == RESP) || ((state_q == REQ) && bus.mem_gnt));
        state_d    = state_q;
        mem_we_d   = mem_we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        we_d       = we_q;
        wb_valid_d = 1'b0;
        wb_we_d    = wb_we_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        fault_d    = fault_q;
        stall_d    = (bus.in_valid && !bus.in_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        case (state_q)
            IDLE: begin
                if (accept && !is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = bus.in_we;
                    wb_rd_d    = bus.in_rd;
                    wb_data_d  = bus.in_rslt;
                end else if (accept && bus.in_rslt[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                end else if (accept) begin
                    state_d  = REQ;
                    mem_we_d = (bus.in_opcode == SW_OPCODE);
                    addr_d   = bus.in_rslt[31:2];
                    wdata_d  = bus.in_rrt;
                    rd_d     = bus.in_rd;
                    we_d     = bus.in_we;
                end
            end
            REQ: begin
                if (bus.mem_gnt && mem_we_q) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b0;
                    wb_rd_d    = 5'd0;
                    wb_data_d  = 32'd0;
                end else if (bus.mem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = RESP;
            default: state_d = IDLE;
        endcase
        // zero-latency grant+rvalid and a later rvalid in RESP retire the same way
        if (load_done) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_we_d    = we_q;
            wb_rd_d    = rd_q;
            wb_data_d  = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            fault_q    <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= 1'b1;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            fault_q    <= fault_d;
            stall_q    <= stall_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a behavioural memory and instruction model
module tb_mem_stage;
    localparam logic [5:0] LW = 6'h23;
    localparam logic [5:0] SW = 6'h2B;

    typedef struct {logic m; logic we; logic [4:0] rd; logic [31:0] d;} beat_t;
    typedef struct {logic we; logic [29:0] a; logic [31:0] d;} req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus();
    mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

    beat_t       beatq[$];
    req_t        reqq[$];
    logic [31:0] mmod  [logic [29:0]];
    logic [31:0] mresp [logic [29:0]];
    int   checks = 0, errors = 0, stall_exp = 0;
    logic exp_fault = 1'b0, outstanding = 1'b0, armed;
    bit   hold_resp = 0, fix_mode = 0, fix_zero = 0, pend = 0;
    int   fix_gnt = 0, fix_rv = 0;

    always @(posedge clk or negedge rst) armed <= rst;

    function automatic logic [31:0] dflt(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural effect of one accepted instruction
    task automatic model(input logic [5:0] op, input logic [31:0] r, input logic [31:0] rt,
                         input logic [4:0] rd, input logic we);
        logic [29:0] a;
        a = r[31:2];
        if (op == LW || op == SW) begin
            if (r[1:0] != 2'b00) exp_fault = 1'b1;
            else begin
                reqq.push_back('{op == SW, a, rt});
                outstanding = 1'b1;
                if (op == SW) begin
                    mmod[a] = rt;
                    beatq.push_back('{1'b1, 1'b0, 5'd0, 32'd0});
                end else beatq.push_back('{1'b1, we, rd, mmod.exists(a) ? mmod[a] : dflt(a)});
            end
        end else beatq.push_back('{1'b0, we, rd, r});
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] r, input logic [31:0] rt,
                         input logic [4:0] rd, input logic we);
        bit acc = 0;
        for (int k = 0; k < 300 && !acc; k++) begin
            bus.in_valid = 1'b1;
            #1;
            if (bus.in_ready) begin
                bus.in_opcode = op; bus.in_rslt = r; bus.in_rrt = rt; bus.in_rd = rd; bus.in_we = we;
                model(op, r, rt, rd, we);
                acc = 1;
            end else begin
                bus.in_opcode = 6'($urandom); bus.in_rslt = $urandom; bus.in_rrt = $urandom;
                bus.in_rd = 5'($urandom); bus.in_we = 1'($urandom);
                if (stall_exp < 65535) stall_exp++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got no accept expected accept within 300 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && beatq.size() > 0; k++) @(negedge clk);
        chk("drain_pending_beats", 32'(beatq.size()), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        chk({tag, "_wb_we"}, 32'(bus.wb_we), 32'd0);
        chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
        chk({tag, "_wb_data"}, bus.wb_data, 32'd0);
        chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
        chk({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
    endtask

    // Memory responder: checks requests against the expected request queue
    initial begin
        int dly = 0, wait_n = 0;
        logic [31:0] pdata = 0;
        req_t q;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
            if (pend) begin
                if (!hold_resp) begin
                    if (dly == 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = pdata; pend = 0; end
                    else dly--;
                end
                if (!fix_mode && $urandom_range(3) == 0) bus.mem_gnt = 1'b1;
            end else if (rst && bus.mem_req) begin
                if (reqq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_req_unexpected: got mem_req=1 addr=%h expected no request", bus.mem_addr);
                end else begin
                    chk("mem_we", 32'(bus.mem_we), 32'(reqq[0].we));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(reqq[0].a));
                    if (reqq[0].we) chk("mem_wdata", bus.mem_wdata, reqq[0].d);
                    if (fix_mode ? (wait_n >= fix_gnt) : ($urandom_range(1) == 0)) begin
                        q = reqq.pop_front();
                        bus.mem_gnt = 1'b1; wait_n = 0;
                        if (q.we) mresp[q.a] = q.d;
                        else begin
                            pdata = mresp.exists(q.a) ? mresp[q.a] : dflt(q.a);
                            if (fix_mode ? fix_zero : ($urandom_range(3) == 0)) begin
                                bus.mem_rvalid = 1'b1; bus.mem_rdata = pdata;
                            end else begin
                                pend = 1; dly = fix_mode ? fix_rv : int'($urandom_range(3));
                            end
                        end
                    end else begin
                        wait_n++;
                        if (!fix_mode && $urandom_range(7) == 0) bus.mem_rvalid = 1'b1;
                    end
                end
            end else if (!fix_mode) begin
                bus.mem_gnt = ($urandom_range(7) == 0);
                bus.mem_rvalid = ($urandom_range(7) == 0);
            end
        end
    end

    // Writeback monitor
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.wb_valid) begin
                    if (beatq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wb_unexpected: got beat rd=%0d data=%h expected none", bus.wb_rd, bus.wb_data);
                    end else begin
                        b = beatq.pop_front();
                        chk("wb_we", 32'(bus.wb_we), 32'(b.we));
                        chk("wb_rd", 32'(bus.wb_rd), 32'(b.rd));
                        chk("wb_data", bus.wb_data, b.d);
                        if (b.m) outstanding = 1'b0;
                    end
                end
                chk("in_ready", 32'(bus.in_ready), 32'(armed && !outstanding));
                chk("fault", 32'(bus.fault), 32'(exp_fault));
            end
        end
    end

    initial begin
        logic [5:0] op;
        logic [31:0] r;
        int sel;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rslt = '0; bus.in_rrt = '0;
        bus.in_rd = '0; bus.in_we = 1'b0;
        #12 reset_checks("reset");
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk);

        issue(6'h00, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
        issue(6'h00, 32'hFFFF_FFFF, 32'd0, 5'd6, 1'b1);
        chk("b2b_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        mmod[30'h41] = 32'hDEAD_BEEF; mresp[30'h41] = 32'hDEAD_BEEF;
        mmod[30'h80] = 32'h1;         mresp[30'h80] = 32'h1;
        fix_mode = 1; fix_gnt = 1; fix_rv = 2; fix_zero = 0;
        issue(LW, 32'h0000_0104, $urandom, 5'd7, 1'b1);
        issue(6'h00, 32'h55, 32'd0, 5'd8, 1'b1);
        chk("lw_stall_cnt", 32'(bus.stall_cnt), 32'd5);

        fix_gnt = 0;
        issue(SW, 32'h0000_0010, 32'hCAFE_F00D, 5'd9, 1'b1);
        fix_zero = 1;
        issue(LW, 32'h0000_0200, 32'd0, 5'd10, 1'b1);
        fix_zero = 0;
        issue(LW, 32'h0000_0102, 32'd0, 5'd11, 1'b1);
        for (int i = 0; i < 4; i++) issue(6'h08, $urandom, 32'd0, 5'(i), 1'b1);
        drain();
        chk("fault_sticky", 32'(bus.fault), 32'd1);
        chk("stall_dir", 32'(bus.stall_cnt), 32'(stall_exp));

        fix_mode = 0;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(9));
            op = 6'($urandom);
            if (op == LW || op == SW) op = 6'h00;
            if (sel >= 4) op = (sel < 7) ? LW : SW;
            r = $urandom;
            if (op == LW || op == SW) r = {22'd0, 8'($urandom), ($urandom_range(9) == 0) ? 2'($urandom) : 2'b00};
            issue(op, r, $urandom, 5'($urandom), 1'($urandom));
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();
        chk("stall_rand", 32'(bus.stall_cnt), 32'(stall_exp));

        fix_mode = 1; fix_gnt = 0; fix_rv = 2; hold_resp = 1;
        issue(LW, 32'h0000_0040, 32'd0, 5'd12, 1'b1);
        for (int k = 0; k < 20 && !pend; k++) @(negedge clk);
        chk("resp_pending", 32'(pend), 32'd1);
        @(negedge clk); #2 rst = 1'b0;
        #1 reset_checks("midreset");
        beatq.delete(); reqq.delete(); outstanding = 1'b0; exp_fault = 1'b0; stall_exp = 0;
        @(negedge clk); @(negedge clk); #2 rst = 1'b1;
        hold_resp = 0;
        repeat (6) @(negedge clk);
        chk("late_rvalid_stall", 32'(bus.stall_cnt), 32'd0);
        issue(6'h00, 32'h0BAD_F00D, 32'd0, 5'd13, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
